// File: rtl/traffic_phase_ctrl_if.sv
// Bus between a traffic_phase_ctrl and its host.
// The host supplies the phase table and requests; the controller returns lamps and status.
interface traffic_phase_ctrl_if #(
  parameter int NUM_APPR   = 4,
  parameter int NUM_PHASES = 6,
  parameter int CNT_W      = 8
);
  localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic [NUM_PHASES*NUM_APPR-1:0] green_mask;
  logic [NUM_PHASES*CNT_W-1:0]    green_time;
  logic [NUM_PHASES-1:0]          phase_en;
  logic                           flash;
  logic                           emg;
  logic [IDX_W-1:0]               emg_phase;
  logic [NUM_APPR-1:0]            lamp_r;
  logic [NUM_APPR-1:0]            lamp_y;
  logic [NUM_APPR-1:0]            lamp_g;
  logic [IDX_W-1:0]               phase_idx;
  logic [2:0]                     state;
  logic                           tick;

  modport master (
    output green_mask, green_time, phase_en, flash, emg, emg_phase,
    input  lamp_r, lamp_y, lamp_g, phase_idx, state, tick
  );

  modport slave (
    input  green_mask, green_time, phase_en, flash, emg, emg_phase,
    output lamp_r, lamp_y, lamp_g, phase_idx, state, tick
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Round-robin multi-phase traffic-light sequencer with yellow/all-red clearance,
// phase skipping, flashing-yellow mode and emergency pre-emption, stepped by a tick prescaler.
module traffic_phase_ctrl #(
  parameter int DIVISOR    = 12000000,
  parameter int NUM_APPR   = 4,
  parameter int NUM_PHASES = 6,
  parameter int CNT_W      = 8,
  parameter int YELLOW_T   = 2,
  parameter int ALLRED_T   = 1
) (
  input logic                clk,
  input logic                rst,
  traffic_phase_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int PS_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(DIVISOR - 1);
  localparam logic [PS_W-1:0]  PS_ONE   = PS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] Y_LOAD   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LOAD  = CNT_W'(ALLRED_T - 1);
  localparam logic [IDX_W:0]   NPH      = (IDX_W + 1)'(NUM_PHASES);
  localparam logic [IDX_W:0]   IDXP_ONE = (IDX_W + 1)'(1);

  typedef enum logic [2:0] {
    ST_ALLRED  = 3'd0,
    ST_GREEN   = 3'd1,
    ST_YELLOW  = 3'd2,
    ST_FLASH   = 3'd3,
    ST_PREEMPT = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    timer_r, timer_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [IDX_W-1:0]    emg_ph_r, emg_ph_s;
  logic [IDX_W-1:0]    nxt_s;
  logic                incl_r, incl_s;
  logic                pend_r, pend_s;
  logic                fy_r, fy_s;
  logic [PS_W-1:0]     ps_r, ps_s;
  logic                tick_r;
  logic [NUM_APPR-1:0] m_s;
  logic [NUM_APPR-1:0] lamp_r_r, lamp_y_r, lamp_g_r;
  logic [NUM_APPR-1:0] lamp_r_s, lamp_y_s, lamp_g_s;

  function automatic logic [NUM_APPR-1:0] mask_of(
    input logic [NUM_PHASES*NUM_APPR-1:0] gm,
    input logic [IDX_W-1:0]               idx
  );
    logic [NUM_APPR-1:0] m;
    m = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (idx == IDX_W'(p)) m = gm[p*NUM_APPR +: NUM_APPR];
    end
    return m;
  endfunction

  // A programmed green time of zero still yields one tick of green.
  function automatic logic [CNT_W-1:0] green_load(
    input logic [NUM_PHASES*CNT_W-1:0] gt,
    input logic [IDX_W-1:0]            idx
  );
    logic [CNT_W-1:0] t;
    t = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (idx == IDX_W'(p)) t = gt[p*CNT_W +: CNT_W];
    end
    return (t == '0) ? '0 : (t - CNT_ONE);
  endfunction

  // First enabled phase after cur (cur itself last), or from phase 0 inclusive when from_zero.
  function automatic logic [IDX_W-1:0] next_phase(
    input logic [NUM_PHASES-1:0] en,
    input logic [IDX_W-1:0]      cur,
    input logic                  from_zero
  );
    logic [IDX_W:0]           base;
    logic [IDX_W:0]           cand;
    logic [2*NUM_PHASES-1:0]  dbl;
    logic [IDX_W-1:0]         res;
    base = from_zero ? '0 : ({1'b0, cur} + IDXP_ONE);
    if (base >= NPH) base = '0;
    dbl  = {en, en} >> base;
    res  = '0;
    cand = '0;
    for (int k = NUM_PHASES - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        cand = base + (IDX_W + 1)'(k);
        if (cand >= NPH) cand = cand - NPH;
        res = cand[IDX_W-1:0];
      end
    end
    return res;
  endfunction

  // Prescaler next count.
  always_comb begin
    ps_s = (ps_r == PS_LAST) ? '0 : (ps_r + PS_ONE);
  end

  // Prescaler register; tick_r is high exactly while ps_r == DIVISOR-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_r   <= '0;
      tick_r <= 1'b0;
    end else begin
      ps_r   <= ps_s;
      tick_r <= (ps_s == PS_LAST);
    end
  end

  // Next-state, timer, phase and pre-emption bookkeeping; everything moves only on tick edges.
  always_comb begin
    state_s  = state_r;
    timer_s  = timer_r;
    idx_s    = idx_r;
    incl_s   = incl_r;
    pend_s   = pend_r;
    emg_ph_s = emg_ph_r;
    fy_s     = fy_r;
    nxt_s    = next_phase(bus.phase_en, idx_r, incl_r);

    if (!tick_r) begin
      state_s = state_r;
    end else if (bus.flash && (state_r != ST_FLASH)) begin
      state_s = ST_FLASH;
      fy_s    = 1'b1;
      pend_s  = 1'b0;
    end else begin
      // The target phase is frozen once PREEMPT is reached.
      if (bus.emg && !bus.flash && (state_r != ST_PREEMPT)) begin
        pend_s   = 1'b1;
        emg_ph_s = bus.emg_phase;
      end else begin
        pend_s   = pend_r;
      end

      case (state_r)
        ST_ALLRED: begin
          if (timer_r != '0) begin
            timer_s = timer_r - CNT_ONE;
          end else if (pend_s) begin
            state_s = ST_PREEMPT;
            idx_s   = emg_ph_s;
            pend_s  = 1'b0;
            incl_s  = 1'b0;
          end else if (!(|bus.phase_en)) begin
            state_s = ST_FLASH;
            fy_s    = 1'b1;
          end else begin
            state_s = ST_GREEN;
            idx_s   = nxt_s;
            timer_s = green_load(bus.green_time, nxt_s);
            incl_s  = 1'b0;
          end
        end
        ST_GREEN: begin
          if (bus.emg && (bus.emg_phase == idx_r)) begin
            state_s = ST_PREEMPT;
            pend_s  = 1'b0;
          end else if (bus.emg || (timer_r == '0)) begin
            state_s = ST_YELLOW;
            timer_s = Y_LOAD;
          end else begin
            timer_s = timer_r - CNT_ONE;
          end
        end
        ST_YELLOW: begin
          if (timer_r != '0) begin
            timer_s = timer_r - CNT_ONE;
          end else begin
            state_s = ST_ALLRED;
            timer_s = AR_LOAD;
          end
        end
        ST_FLASH: begin
          if (!bus.flash && (|bus.phase_en)) begin
            state_s = ST_ALLRED;
            timer_s = AR_LOAD;
            idx_s   = '0;
            incl_s  = 1'b1;
            fy_s    = 1'b0;
          end else begin
            fy_s    = ~fy_r;
          end
        end
        ST_PREEMPT: begin
          if (!bus.emg) begin
            state_s = ST_YELLOW;
            timer_s = Y_LOAD;
          end else begin
            state_s = ST_PREEMPT;
          end
        end
        default: begin
          state_s = ST_ALLRED;
          timer_s = AR_LOAD;
          idx_s   = '0;
          incl_s  = 1'b1;
          pend_s  = 1'b0;
        end
      endcase
    end
  end

  // Lamp decode from the upcoming state so lamps register alongside it; one lamp per approach at most.
  always_comb begin
    m_s      = mask_of(bus.green_mask, idx_s);
    lamp_r_s = '1;
    lamp_y_s = '0;
    lamp_g_s = '0;
    case (state_s)
      ST_GREEN, ST_PREEMPT: begin
        lamp_g_s = m_s;
        lamp_r_s = ~m_s;
      end
      ST_YELLOW: begin
        lamp_y_s = m_s;
        lamp_r_s = ~m_s;
      end
      ST_FLASH: begin
        lamp_r_s = '0;
        lamp_y_s = {NUM_APPR{fy_s}};
      end
      default: begin
        lamp_r_s = '1;
      end
    endcase
  end

  // Sequencer state and lamp registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_ALLRED;
      timer_r  <= AR_LOAD;
      idx_r    <= '0;
      incl_r   <= 1'b1;
      pend_r   <= 1'b0;
      emg_ph_r <= '0;
      fy_r     <= 1'b0;
      lamp_r_r <= '1;
      lamp_y_r <= '0;
      lamp_g_r <= '0;
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      idx_r    <= idx_s;
      incl_r   <= incl_s;
      pend_r   <= pend_s;
      emg_ph_r <= emg_ph_s;
      fy_r     <= fy_s;
      lamp_r_r <= lamp_r_s;
      lamp_y_r <= lamp_y_s;
      lamp_g_r <= lamp_g_s;
    end
  end

  assign bus.lamp_r    = lamp_r_r;
  assign bus.lamp_y    = lamp_y_r;
  assign bus.lamp_g    = lamp_g_r;
  assign bus.phase_idx = idx_r;
  assign bus.state     = state_r;
  assign bus.tick      = tick_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed-vector bench for traffic_phase_ctrl with DIVISOR=4, 4 approaches, 3 phases.
// Also watches every clock that no approach goes green->red, or yellow->red too early, or lights two lamps.
module tb_traffic_phase_ctrl;
  localparam int DIV = 4;
  localparam int NA  = 4;
  localparam int NP  = 3;
  localparam int CW  = 8;
  localparam int YT  = 2;
  localparam int ART = 1;

  localparam logic [3:0] M0 = 4'b0011;
  localparam logic [3:0] M1 = 4'b0100;
  localparam logic [3:0] M2 = 4'b1000;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   viol  = 0;

  traffic_phase_ctrl_if #(.NUM_APPR(NA), .NUM_PHASES(NP), .CNT_W(CW)) bus ();

  traffic_phase_ctrl #(
    .DIVISOR(DIV), .NUM_APPR(NA), .NUM_PHASES(NP), .CNT_W(CW),
    .YELLOW_T(YT), .ALLRED_T(ART)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected lamps from state and pattern: pat is the green mask, or the yellow pattern in FLASH.
  task automatic check_out(input string tag, input logic [2:0] st, input logic [1:0] idx,
                           input logic [3:0] pat);
    logic [3:0] er, ey, eg;
    case (st)
      3'd1, 3'd4: begin eg = pat;  er = ~pat;  ey = 4'h0; end
      3'd2:       begin ey = pat;  er = ~pat;  eg = 4'h0; end
      3'd3:       begin ey = pat;  er = 4'h0;  eg = 4'h0; end
      default:    begin er = 4'hF; ey = 4'h0;  eg = 4'h0; end
    endcase
    check_eq({tag, ".state"}, 32'(bus.state), 32'(st));
    check_eq({tag, ".idx"},   32'(bus.phase_idx), 32'(idx));
    check_eq({tag, ".r"},     32'(bus.lamp_r), 32'(er));
    check_eq({tag, ".y"},     32'(bus.lamp_y), 32'(ey));
    check_eq({tag, ".g"},     32'(bus.lamp_g), 32'(eg));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tk(input int n);
    repeat (n * DIV) @(negedge clk);
  endtask

  // Lamp-safety watcher.
  logic [3:0] p_g = 4'h0;
  logic [3:0] p_y = 4'h0;
  logic       p_fl = 1'b0;
  logic       mon_v = 1'b0;
  int         yrun [NA];

  function automatic int lamp_bad(input logic [3:0] r, input logic [3:0] y, input logic [3:0] g,
                                  input logic [3:0] pg, input logic [3:0] py, input logic pfl,
                                  input int yr [NA]);
    int b;
    b = 0;
    for (int k = 0; k < NA; k++) begin
      if ((r[k] & y[k]) | (r[k] & g[k]) | (y[k] & g[k])) b++;
      if (pg[k] && r[k]) b++;
      if (py[k] && r[k] && !pfl && (yr[k] < YT * DIV)) b++;
    end
    return b;
  endfunction

  always @(negedge clk) begin
    if (rst || !mon_v) begin
      mon_v <= !rst;
    end else begin
      viol <= viol + lamp_bad(bus.lamp_r, bus.lamp_y, bus.lamp_g, p_g, p_y, p_fl, yrun);
    end
    p_g  <= bus.lamp_g;
    p_y  <= bus.lamp_y;
    p_fl <= (bus.state == 3'd3);
    for (int k = 0; k < NA; k++) yrun[k] <= bus.lamp_y[k] ? (yrun[k] + 1) : 0;
  end

  initial begin
    for (int k = 0; k < NA; k++) yrun[k] = 0;
    rst            = 1'b1;
    bus.green_mask = {M2, M1, M0};
    bus.green_time = {8'd1, 8'd2, 8'd3};
    bus.phase_en   = 3'b111;
    bus.flash      = 1'b0;
    bus.emg        = 1'b0;
    bus.emg_phase  = 2'd0;
    cyc(2);
    check_out("reset", 3'd0, 2'd0, 4'h0);
    check_eq("reset.tick", 32'(bus.tick), 32'd0);
    rst = 1'b0;

    // 1: all red one tick, then 0 -> 1 -> 2 -> 0 in 15 ticks
    cyc(1);  check_eq("t1.tick_lo", 32'(bus.tick), 32'd0);
    cyc(2);  check_eq("t1.tick_hi", 32'(bus.tick), 32'd1);
             check_out("t1.ar_hold", 3'd0, 2'd0, 4'h0);
    cyc(1);  check_out("t1.g0", 3'd1, 2'd0, M0);
    tk(2);   check_out("t1.g0_end", 3'd1, 2'd0, M0);
    tk(1);   check_out("t1.y0", 3'd2, 2'd0, M0);
    tk(2);   check_out("t1.ar0", 3'd0, 2'd0, 4'h0);
    tk(1);   check_out("t1.g1", 3'd1, 2'd1, M1);
    tk(2);   check_out("t1.y1", 3'd2, 2'd1, M1);
    tk(2);   check_out("t1.ar1", 3'd0, 2'd1, 4'h0);
    tk(1);   check_out("t1.g2", 3'd1, 2'd2, M2);
    tk(1);   check_out("t1.y2", 3'd2, 2'd2, M2);
    tk(2);   check_out("t1.ar2", 3'd0, 2'd2, 4'h0);
    tk(1);   check_out("t1.g0_again", 3'd1, 2'd0, M0);

    // 2: skip phase 1, then disable all mid-green
    bus.phase_en = 3'b101;
    tk(6);   check_out("t2.g2", 3'd1, 2'd2, M2);
    tk(4);   check_out("t2.g0", 3'd1, 2'd0, M0);
    bus.phase_en = 3'b000;
    tk(3);   check_out("t2.y0", 3'd2, 2'd0, M0);
    tk(2);   check_out("t2.ar", 3'd0, 2'd0, 4'h0);
    tk(1);   check_out("t2.flash_on", 3'd3, 2'd0, 4'hF);
    tk(1);   check_out("t2.flash_off", 3'd3, 2'd0, 4'h0);
    bus.phase_en = 3'b111;
    tk(1);   check_out("t2.exit_ar", 3'd0, 2'd0, 4'h0);
    tk(1);   check_out("t2.exit_g0", 3'd1, 2'd0, M0);

    // 3: flash request during G1
    tk(6);   check_out("t3.g1", 3'd1, 2'd1, M1);
    bus.flash = 1'b1;
    tk(1);   check_out("t3.fl1", 3'd3, 2'd1, 4'hF);
    tk(1);   check_out("t3.fl2", 3'd3, 2'd1, 4'h0);
    tk(1);   check_out("t3.fl3", 3'd3, 2'd1, 4'hF);
    bus.flash = 1'b0;
    tk(1);   check_out("t3.ar", 3'd0, 2'd0, 4'h0);
    tk(1);   check_out("t3.g0", 3'd1, 2'd0, M0);

    // 4: pre-emption of phase 1 during G0
    bus.emg       = 1'b1;
    bus.emg_phase = 2'd1;
    tk(1);   check_out("t4.y0a", 3'd2, 2'd0, M0);
    tk(1);   check_out("t4.y0b", 3'd2, 2'd0, M0);
    tk(1);   check_out("t4.ar", 3'd0, 2'd0, 4'h0);
    tk(1);   check_out("t4.pre_first", 3'd4, 2'd1, M1);
    tk(2);   bus.emg_phase = 2'd2;
    tk(7);   check_out("t4.pre_last", 3'd4, 2'd1, M1);
    bus.emg = 1'b0;
    tk(1);   check_out("t4.y1", 3'd2, 2'd1, M1);
    tk(2);   check_out("t4.ar1", 3'd0, 2'd1, 4'h0);
    tk(1);   check_out("t4.g2", 3'd1, 2'd2, M2);

    // 5: asynchronous reset while yellow and tick are both high
    tk(1);   check_out("t5.y2", 3'd2, 2'd2, M2);
    cyc(3);  check_eq("t5.tick_before", 32'(bus.tick), 32'd1);
    #2 rst = 1'b1;
    #1 check_out("t5.async", 3'd0, 2'd0, 4'h0);
    check_eq("t5.async_tick", 32'(bus.tick), 32'd0);
    bus.green_time = {8'd1, 8'd2, 8'd0};
    cyc(2);
    #2 rst = 1'b0;
    cyc(3);  check_eq("t5.first_tick", 32'(bus.tick), 32'd1);
             check_out("t5.still_ar", 3'd0, 2'd0, 4'h0);
    cyc(1);  check_out("t5.g0", 3'd1, 2'd0, M0);

    // 6: green time 0 lasts one tick, 255 lasts 255 ticks
    tk(1);   check_out("t6.gt0_y0", 3'd2, 2'd0, M0);
    tk(8);   check_out("t6.g2", 3'd1, 2'd2, M2);
    bus.green_time = {8'd1, 8'd2, 8'd255};
    tk(4);   check_out("t6.g0_start", 3'd1, 2'd0, M0);
    tk(254); check_out("t6.g0_end", 3'd1, 2'd0, M0);
    tk(1);   check_out("t6.y0", 3'd2, 2'd0, M0);

    cyc(1);
    check_eq("lamp_safety", 32'(viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
